// File: rtl/pr_timer.sv
// Programmable interval timer on the processor bus: CTRL/PRESET/COUNT window,
// one-shot or auto-reload down-counter, level interrupt gated by IM.
module pr_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:2] PrAddr,
  input  logic [3:0]  PrBe,
  input  logic [31:0] PrWD,
  output logic [31:0] PrRD,
  output logic        hit,
  output logic        irq
);

  localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  ctrl_reg;
  logic [31:0] preset_reg, preset_next;
  logic [31:0] count_reg, count_next;
  logic        pend_reg, pend_next;
  logic        pend_set;
  logic        en_clr;

  logic [29:0] word_off;
  logic [1:0]  sel;
  logic        wr, wr_ctrl, wr_preset;

  logic        en;
  logic [1:0]  mode;

  assign en   = ctrl_reg[0];
  assign mode = ctrl_reg[2:1];

  // Offset relative to the window base; anything past the third word misses.
  assign word_off  = PrAddr - BASE_WORD;
  assign hit       = (word_off < 30'd3);
  assign sel       = word_off[1:0];
  assign wr        = hit && (PrBe != 4'd0);
  assign wr_ctrl   = wr && (sel == 2'd0);
  assign wr_preset = wr && (sel == 2'd1);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_preset_byte
      assign preset_next[8*gi +: 8] = (wr_preset && PrBe[gi]) ? PrWD[8*gi +: 8]
                                                              : preset_reg[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    PrRD = '0;
    if (hit) begin
      case (sel)
        2'd0:    PrRD = {28'd0, ctrl_reg};
        2'd1:    PrRD = preset_reg;
        2'd2:    PrRD = count_reg;
        default: PrRD = '0;
      endcase
    end
  end

  assign irq = pend_reg & ctrl_reg[3];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    pend_next  = pend_reg;
    pend_set   = 1'b0;
    en_clr     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (en) state_next = LOAD;
      end
      LOAD: begin
        count_next = preset_reg;
        if (!en) begin
          state_next = IDLE;
        end else if (preset_reg == 32'd0) begin
          state_next = INT;
          pend_set   = 1'b1;
        end else begin
          state_next = CNT;
        end
      end
      CNT: begin
        if (!en) begin
          state_next = IDLE;
        end else begin
          if (count_reg != 32'd0) count_next = count_reg - 32'd1;
          if (count_reg <= 32'd1) begin
            state_next = INT;
            pend_set   = 1'b1;
          end
        end
      end
      INT: begin
        if (mode == 2'b01) begin
          state_next = LOAD;
          pend_next  = 1'b0;
        end else begin
          state_next = IDLE;
          en_clr     = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // A fresh expiry outranks the acknowledge carried by a CTRL store.
    if (pend_set) begin
      pend_next = 1'b1;
    end else if (wr_ctrl) begin
      pend_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_reg   <= 4'd0;
      preset_reg <= 32'd0;
      count_reg  <= 32'd0;
      pend_reg   <= 1'b0;
    end else begin
      // CPU data for CTRL wins over the one-shot auto-disable.
      if (wr_ctrl && PrBe[0]) begin
        ctrl_reg <= PrWD[3:0];
      end else if (en_clr) begin
        ctrl_reg[0] <= 1'b0;
      end
      preset_reg <= preset_next;
      count_reg  <= count_next;
      pend_reg   <= pend_next;
    end
  end

endmodule

// File: tb/tb_pr_timer.sv
// Self-checking bench for pr_timer: register reads go through a scoreboard
// queue, irq/hit are compared directly through the same check task.
module tb_pr_timer;

  localparam logic [29:0] BASE_W = 30'h1FC0;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] pr_addr;
  logic [3:0]  pr_be;
  logic [31:0] pr_wd;
  logic [31:0] pr_rd;
  logic        hit;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic        rd_req = 1'b0;

  always #5 clk = ~clk;

  pr_timer dut (
    .clk   (clk),
    .rst   (rst),
    .PrAddr(pr_addr),
    .PrBe  (pr_be),
    .PrWD  (pr_wd),
    .PrRD  (pr_rd),
    .hit   (hit),
    .irq   (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Read monitor: pops the expected value pushed by the read stimulus.
  always @(negedge clk) begin
    if (rd_req) begin
      if (exp_q.size() == 0 || tag_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        check(tag_q.pop_front(), pr_rd, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] off, input logic [3:0] be, input logic [31:0] data);
    pr_addr = BASE_W + 30'(off);
    pr_be   = be;
    pr_wd   = data;
    tick();
    pr_be   = 4'd0;
  endtask

  task automatic bus_read(input logic [1:0] off, input logic [31:0] exp, input string tag);
    pr_addr = BASE_W + 30'(off);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    rd_req = 1'b1;
    @(negedge clk);
    #1;
    rd_req = 1'b0;
  endtask

  initial begin
    int pulses;
    rst     = 1'b0;
    pr_addr = BASE_W;
    pr_be   = 4'd0;
    pr_wd   = 32'd0;
    repeat (3) tick();

    // Power-on reset state
    check("rst0_irq", {31'd0, irq}, 32'd0);
    bus_read(2'd0, 32'd0, "rst0_ctrl");
    rst = 1'b1;
    tick();
    bus_read(2'd1, 32'd0, "rst0_preset");
    bus_read(2'd2, 32'd0, "rst0_count");

    // One-shot, PRESET=5
    bus_write(2'd1, 4'hF, 32'd5);
    bus_write(2'd0, 4'hF, 32'h9);
    tick();
    tick();
    bus_read(2'd2, 32'd5, "os_load");
    check("os_irq0", {31'd0, irq}, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      bus_read(2'd2, 32'(5 - k), $sformatf("os_count%0d", k));
      check($sformatf("os_irq%0d", k), {31'd0, irq}, (k == 5) ? 32'd1 : 32'd0);
    end
    tick();
    tick();
    check("os_irq_hold", {31'd0, irq}, 32'd1);
    bus_read(2'd0, 32'h8, "os_ctrl_en_cleared");
    bus_read(2'd2, 32'd0, "os_count_final");
    bus_write(2'd0, 4'hF, 32'h8);
    check("os_irq_ack", {31'd0, irq}, 32'd0);

    // Auto-reload, PRESET=3: period 5, one-cycle pulse
    bus_write(2'd1, 4'hF, 32'd3);
    bus_write(2'd0, 4'hF, 32'hB);
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (irq) pulses++;
      check($sformatf("ar_irq_e%0d", k), {31'd0, irq}, (k % 5 == 0) ? 32'd1 : 32'd0);
    end
    check("ar_pulses", 32'(pulses), 32'd4);

    // Asynchronous reset while irq is high
    #2;
    rst = 1'b0;
    #1;
    check("rst_irq_async", {31'd0, irq}, 32'd0);
    bus_read(2'd0, 32'd0, "rst_ctrl");
    bus_read(2'd1, 32'd0, "rst_preset");
    bus_read(2'd2, 32'd0, "rst_count");
    pr_addr = 30'h0BFF;
    #1;
    check("rst_hit_2ffc", {31'd0, hit}, 32'd0);
    tick();
    rst = 1'b1;

    // Masked interrupt: IM=0 never asserts irq
    bus_write(2'd1, 4'hF, 32'd2);
    bus_write(2'd0, 4'hF, 32'h1);
    repeat (4) tick();
    bus_read(2'd2, 32'd0, "mask_count0");
    check("mask_irq", {31'd0, irq}, 32'd0);
    tick();
    check("mask_irq_idle", {31'd0, irq}, 32'd0);
    bus_read(2'd0, 32'd0, "mask_ctrl");

    // Disable mid-count freezes COUNT
    bus_write(2'd1, 4'hF, 32'd10);
    bus_write(2'd0, 4'hF, 32'h9);
    check("dis_irq_start", {31'd0, irq}, 32'd0);
    repeat (8) tick();
    bus_read(2'd2, 32'd4, "dis_count4");
    bus_write(2'd0, 4'hF, 32'h8);
    bus_read(2'd2, 32'd3, "dis_count_edge");
    repeat (3) tick();
    bus_read(2'd2, 32'd3, "dis_count_frozen");
    check("dis_irq", {31'd0, irq}, 32'd0);

    // Byte enables and read-only COUNT
    bus_write(2'd1, 4'hF, 32'd0);
    bus_write(2'd1, 4'b0101, 32'hAABB_CCDD);
    bus_read(2'd1, 32'h00BB_00DD, "be_preset");
    bus_write(2'd2, 4'hF, 32'hFFFF_FFFF);
    bus_read(2'd2, 32'd3, "count_ro");
    bus_read(2'd3, 32'd0, "off3_rd");
    check("off3_hit", {31'd0, hit}, 32'd0);
    pr_addr = BASE_W;
    #1;
    check("base_hit", {31'd0, hit}, 32'd1);

    // PRESET=0: LOAD goes straight to INT
    bus_write(2'd1, 4'hF, 32'd0);
    bus_write(2'd0, 4'hF, 32'h9);
    check("p0_irq_e0", {31'd0, irq}, 32'd0);
    tick();
    check("p0_irq_e1", {31'd0, irq}, 32'd0);
    tick();
    check("p0_irq_e2", {31'd0, irq}, 32'd1);
    bus_read(2'd2, 32'd0, "p0_count");
    tick();
    bus_read(2'd0, 32'h8, "p0_ctrl");

    if (exp_q.size() != 0) check("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
